// File: rtl/rangefinder_sopc_spi_slave.sv
// SPI mode-0 slave with an oversampled pin interface and a CPU register port.
// Status, control and interrupt bits use the same layout as the master-side SPI block.
`timescale 1ns/1ps
module rangefinder_sopc_spi_slave #(
    parameter int DATABITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic [2:0]  mem_addr,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    input  logic        read_n,
    input  logic        write_n,
    input  logic        spi_select,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata
);

    localparam int CW = $clog2(DATABITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATABITS - 1);

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
    logic                   r_sclk_d, r_ss_d;
    logic                   r_rd_d, r_wr_d;
    logic [DATABITS-1:0]    r_rx_shift, r_tx_shift, r_rx_hold, r_tx_hold;
    logic [CW-1:0]          r_bitcount;
    logic                   r_tx_primed, r_loaded_empty;
    logic                   r_rrdy, r_toe, r_roe, r_tue;
    logic [8:0]             r_ctrl;
    logic [15:0]            r_data_to_cpu;
    logic                   r_irq;

    logic w_s_sclk, w_s_ss, w_s_mosi, w_sel;
    logic w_rise, w_fall, w_ss_fall, w_ss_rise;
    logic w_rd_strobe, w_wr_strobe;
    logic w_load, w_shift_out, w_rx_edge, w_done;
    logic w_tx_wr, w_tx_ok, w_rx_rd, w_st_wr, w_ctl_wr, w_rrdy_clr;
    logic w_trdy, w_busy, w_tmt, w_e;
    logic [DATABITS-1:0] w_rx_byte;
    logic [15:0] w_status, w_rxdata, w_rd_mux;
    logic w_unused;

    assign w_s_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_s_ss   = r_ss_sync[SYNC_STAGES-1];
    assign w_s_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_sel    = ~w_s_ss;

    assign w_rise    = w_s_sclk & ~r_sclk_d;
    assign w_fall    = ~w_s_sclk & r_sclk_d;
    assign w_ss_fall = ~w_s_ss & r_ss_d;
    assign w_ss_rise = w_s_ss & ~r_ss_d;

    assign w_rd_strobe = spi_select & ~read_n & ~r_rd_d;
    assign w_wr_strobe = spi_select & ~write_n & ~r_wr_d;

    // A fall with bitcount==0 while selected only happens right after a completed byte.
    assign w_load      = w_ss_fall | (w_fall & w_sel & (r_bitcount == '0));
    assign w_shift_out = w_fall & w_sel & (r_bitcount != '0);
    assign w_rx_edge   = w_rise & w_sel;
    assign w_done      = w_rx_edge & (r_bitcount == LAST_BIT);
    assign w_rx_byte   = {r_rx_shift[DATABITS-2:0], w_s_mosi};

    assign w_tx_wr    = w_wr_strobe & (mem_addr == 3'd1);
    assign w_tx_ok    = w_tx_wr & ~r_tx_primed;
    assign w_rx_rd    = w_rd_strobe & (mem_addr == 3'd0);
    assign w_st_wr    = w_wr_strobe & (mem_addr == 3'd2);
    assign w_ctl_wr   = w_wr_strobe & (mem_addr == 3'd3);
    assign w_rrdy_clr = w_rx_rd | w_st_wr;

    assign w_trdy = ~r_tx_primed;
    assign w_busy = w_sel & (r_bitcount != '0);
    assign w_tmt  = ~r_tx_primed & ~w_busy;
    assign w_e    = r_toe | r_roe | r_tue;

    assign w_status = {7'd0, w_e, r_rrdy, w_trdy, w_tmt, r_toe, r_roe, r_tue, 2'b00};

    always_comb begin
        w_rxdata                 = '0;
        w_rxdata[DATABITS-1:0]   = r_rx_hold;
    end

    always_comb begin
        w_rd_mux = '0;
        case (mem_addr)
            3'd0:    w_rd_mux = w_rxdata;
            3'd2:    w_rd_mux = w_status;
            3'd3:    w_rd_mux = {7'd0, r_ctrl};
            default: w_rd_mux = '0;
        endcase
    end

    assign w_unused = ^{data_from_cpu[15:9], r_rx_shift[DATABITS-1]};

    // Pin synchronizers and edge-detect history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
            r_rd_d      <= 1'b0;
            r_wr_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_d    <= w_s_sclk;
            r_ss_d      <= w_s_ss;
            r_rd_d      <= spi_select & ~read_n;
            r_wr_d      <= spi_select & ~write_n;
        end
    end

    // Shift engine: leaving select mid-byte drops the partial byte in both directions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_shift     <= '0;
            r_tx_shift     <= '0;
            r_bitcount     <= '0;
            r_loaded_empty <= 1'b0;
        end else if (w_ss_rise) begin
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_bitcount <= '0;
        end else begin
            if (w_load) begin
                r_tx_shift     <= r_tx_primed ? r_tx_hold : '0;
                r_loaded_empty <= ~r_tx_primed;
            end else if (w_shift_out) begin
                r_tx_shift <= r_tx_shift << 1;
            end
            if (w_rx_edge) begin
                r_rx_shift <= w_rx_byte;
                r_bitcount <= w_done ? '0 : r_bitcount + 1'b1;
            end
        end
    end

    // Holding registers and flags; a byte completion beats a same-cycle RRDY clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_hold   <= '0;
            r_rx_hold   <= '0;
            r_tx_primed <= 1'b0;
            r_rrdy      <= 1'b0;
            r_toe       <= 1'b0;
            r_roe       <= 1'b0;
            r_tue       <= 1'b0;
            r_ctrl      <= '0;
        end else begin
            if (w_tx_ok) begin
                r_tx_hold   <= data_from_cpu[DATABITS-1:0];
                r_tx_primed <= 1'b1;
            end else if (w_load) begin
                r_tx_primed <= 1'b0;
            end

            if (w_tx_wr & r_tx_primed)
                r_toe <= 1'b1;
            else if (w_st_wr)
                r_toe <= 1'b0;

            if (w_done) begin
                r_rx_hold <= w_rx_byte;
                r_rrdy    <= 1'b1;
            end else if (w_rrdy_clr) begin
                r_rrdy <= 1'b0;
            end

            if (w_done & r_rrdy & ~w_rrdy_clr)
                r_roe <= 1'b1;
            else if (w_st_wr)
                r_roe <= 1'b0;

            if (w_rx_edge & (r_bitcount == '0) & r_loaded_empty)
                r_tue <= 1'b1;
            else if (w_st_wr)
                r_tue <= 1'b0;

            if (w_ctl_wr)
                r_ctrl <= data_from_cpu[8:0] & 9'h1DC;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_to_cpu <= '0;
            r_irq         <= 1'b0;
        end else begin
            if (w_rd_strobe)
                r_data_to_cpu <= w_rd_mux;
            r_irq <= (w_e & r_ctrl[8]) | (r_rrdy & r_ctrl[7]) | (w_trdy & r_ctrl[6]) |
                     (r_toe & r_ctrl[4]) | (r_roe & r_ctrl[3]) | (r_tue & r_ctrl[2]);
        end
    end

    assign MISO          = w_sel & r_tx_shift[DATABITS-1];
    assign MISO_oe       = w_sel;
    assign data_to_cpu   = r_data_to_cpu;
    assign irq           = r_irq;
    assign dataavailable = r_rrdy;
    assign readyfordata  = w_trdy;

endmodule

// File: tb/tb_rangefinder_sopc_spi_slave.sv
// Scoreboard bench: stimulus pushes expected CPU reads, MISO bytes and pin states;
// a monitor pops and compares each time the bench flags an observation point.
`timescale 1ns/1ps
module tb_rangefinder_sopc_spi_slave;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        SCLK = 1'b0, SS_n = 1'b1, MOSI = 1'b0;
    logic        MISO, MISO_oe;
    logic [2:0]  mem_addr = 3'd0;
    logic [15:0] data_from_cpu = 16'd0;
    logic [15:0] data_to_cpu;
    logic        read_n = 1'b1, write_n = 1'b1, spi_select = 1'b0;
    logic        irq, dataavailable, readyfordata;

    rangefinder_sopc_spi_slave #(.DATABITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .mem_addr(mem_addr),
        .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
        .read_n(read_n), .write_n(write_n), .spi_select(spi_select),
        .irq(irq), .dataavailable(dataavailable), .readyfordata(readyfordata)
    );

    always #4 clk = ~clk;

    // kind 0: data_to_cpu after a read, 1: byte seen on MISO, 2: pin vector
    typedef struct {
        int          kind;
        string       name;
        logic [20:0] exp;
        logic [20:0] mask;
    } sb_t;

    sb_t        sb_q[$];
    logic       obs_due = 1'b0;
    logic       done = 1'b0;
    logic [7:0] miso_cap = 8'd0;
    int         tests = 0;
    int         fails = 0;

    localparam logic [20:0] M_ALL = 21'h1FFFFF;
    localparam logic [20:0] B_IRQ = 21'h10, B_OE = 21'h08, B_MISO = 21'h04, B_DA = 21'h02, B_RFD = 21'h01;

    function automatic logic [20:0] pins();
        return {data_to_cpu, irq, MISO_oe, MISO, dataavailable, readyfordata};
    endfunction

    // Monitor
    initial begin
        sb_t         e;
        logic [20:0] act;
        forever begin
            @(negedge clk);
            if (obs_due) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_empty: observation with no expected entry");
                end else begin
                    e = sb_q.pop_front();
                    case (e.kind)
                        0:       act = {5'd0, data_to_cpu};
                        1:       act = {13'd0, miso_cap};
                        default: act = pins();
                    endcase
                    if ((act & e.mask) !== (e.exp & e.mask)) begin
                        fails++;
                        $display("FAIL %s: got 0x%0h expected 0x%0h (mask 0x%0h)",
                                 e.name, act & e.mask, e.exp & e.mask, e.mask);
                    end
                end
            end
            if (done) begin
                tests++;
                if (sb_q.size() != 0) begin
                    fails++;
                    $display("FAIL sb_leftover: %0d entries left, expected 0", sb_q.size());
                end
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic observe();
        obs_due = 1'b1;
        @(posedge clk); #1;
        obs_due = 1'b0;
    endtask

    task automatic probe(input string n, input logic [20:0] e, input logic [20:0] m);
        sb_q.push_back('{2, n, e, m});
        @(posedge clk); #1;
        observe();
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
        @(posedge clk); #1;
        @(posedge clk); #1;
        spi_select = 1'b0; write_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [2:0] a, input logic [15:0] e, input string n);
        sb_q.push_back('{0, n, {5'd0, e}, M_ALL});
        @(posedge clk); #1;
        spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
        @(posedge clk); #1;
        observe();
        spi_select = 1'b0; read_n = 1'b1;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mode 0 master: drive MOSI in the low phase, sample MISO just before the rise.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input logic [7:0] exp_miso,
                            input bit chk, input string n);
        logic [7:0] cap;
        cap = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = tx[7-i];
            wait_clk(6);
            cap[7-i] = MISO;
            SCLK = 1'b1;
            wait_clk(6);
            SCLK = 1'b0;
        end
        if (chk) begin
            miso_cap = cap;
            sb_q.push_back('{1, n, {13'd0, exp_miso}, M_ALL});
            observe();
        end
    endtask

    task automatic ss_begin();
        SS_n = 1'b0;
        wait_clk(8);
    endtask

    task automatic ss_end();
        wait_clk(6);
        SS_n = 1'b1;
        wait_clk(8);
    endtask

    initial begin
        // Power-on reset
        wait_clk(3);
        probe("reset_pins", {16'h0000, 5'b00001}, M_ALL);
        reset_n = 1'b1;
        wait_clk(4);
        cpu_read(3'd3, 16'h0000, "ctrl_reset");
        cpu_read(3'd2, 16'h0060, "status_reset");
        cpu_write(3'd3, 16'hFFFF);
        cpu_read(3'd3, 16'h01DC, "ctrl_readback");
        cpu_read(3'd5, 16'h0000, "addr5_zero");
        cpu_write(3'd3, 16'h0000);

        // Reset in the middle of a frame
        cpu_write(3'd1, 16'h005A);
        ss_begin();
        spi_bits(8'hA0, 3, 8'h00, 1'b0, "");
        reset_n = 1'b0;
        probe("midframe_reset_pins", {16'h0000, 5'b00001}, M_ALL);
        SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(10);
        cpu_read(3'd2, 16'h0060, "status_after_midreset");

        // Single byte: tx 0xA5, rx 0x3C
        cpu_write(3'd1, 16'h00A5);
        ss_begin();
        probe("selected_oe_msb", 21'h0D, B_OE | B_MISO | B_RFD);
        spi_bits(8'h3C, 8, 8'hA5, 1'b1, "miso_A5");
        ss_end();
        cpu_read(3'd2, 16'h00E0, "status_after_A5");
        cpu_read(3'd0, 16'h003C, "rxdata_3C");
        cpu_read(3'd2, 16'h0060, "status_rrdy_cleared");

        // Two bytes in one frame, no read between them
        cpu_write(3'd3, 16'h0008);
        cpu_write(3'd1, 16'h0011);
        ss_begin();
        cpu_write(3'd1, 16'h0022);
        spi_bits(8'h5A, 8, 8'h11, 1'b1, "miso_11");
        spi_bits(8'h96, 8, 8'h22, 1'b1, "miso_22");
        ss_end();
        probe("irq_roe", B_IRQ | B_DA | B_RFD, B_IRQ | B_DA | B_RFD | B_OE);
        cpu_read(3'd2, 16'h01E8, "status_roe");
        cpu_read(3'd0, 16'h0096, "rxdata_96");
        cpu_write(3'd2, 16'hFFFF);
        cpu_read(3'd2, 16'h0060, "status_cleared_roe");
        probe("irq_clear_roe", 21'h0, B_IRQ);

        // Underrun: nothing written
        cpu_write(3'd3, 16'h0100);
        ss_begin();
        spi_bits(8'hF0, 8, 8'h00, 1'b1, "miso_underrun");
        ss_end();
        probe("irq_tue", B_IRQ, B_IRQ);
        cpu_read(3'd2, 16'h01E4, "status_tue");
        cpu_write(3'd2, 16'h0000);
        cpu_read(3'd2, 16'h0060, "status_cleared_tue");
        cpu_read(3'd0, 16'h00F0, "rxdata_F0");
        probe("irq_clear_tue", 21'h0, B_IRQ);
        cpu_write(3'd3, 16'h0000);

        // Overrun on txdata while the holding register is full
        cpu_write(3'd1, 16'h0081);
        ss_begin();
        cpu_write(3'd1, 16'h0042);
        probe("trdy_low_full", 21'h0, B_RFD);
        cpu_write(3'd1, 16'h0024);
        spi_bits(8'h01, 8, 8'h81, 1'b1, "miso_81");
        spi_bits(8'h02, 8, 8'h42, 1'b1, "miso_42_kept");
        ss_end();
        cpu_read(3'd2, 16'h01F8, "status_toe");
        cpu_read(3'd0, 16'h0002, "rxdata_02");
        cpu_write(3'd2, 16'h0000);
        cpu_read(3'd2, 16'h0060, "status_cleared_toe");

        // Aborted partial frame followed by a full one
        ss_begin();
        spi_bits(8'hF8, 5, 8'h00, 1'b0, "");
        ss_end();
        probe("between_frames", 21'h0, B_OE | B_DA);
        ss_begin();
        spi_bits(8'hC3, 8, 8'h00, 1'b1, "miso_C3_frame");
        ss_end();
        probe("after_C3", B_DA, B_OE | B_DA);
        cpu_read(3'd2, 16'h01E4, "status_after_partial");
        cpu_read(3'd0, 16'h00C3, "rxdata_C3");

        wait_clk(2);
        done = 1'b1;
    end

endmodule

// File: doc/rangefinder_sopc_spi_slave.md
# rangefinder_sopc_spi_slave

SPI slave (mode 0: CPOL=0, CPHA=0, MSB first, 8-bit frames) with a CPU register port, so the SOPC can sit on the responder end of an SPI link driven by an external master. SCLK, SS_n and MOSI are oversampled in the `clk` domain. Received bytes go to an rx holding register, and transmit bytes come from a tx holding register. Status, interrupt-enable and streaming flags match the master-side SPI register layout.

## Interface
- DATABITS, 8, frame width; the rx/tx registers use bits [DATABITS-1:0].
- SYNC_STAGES, 2, synchronizer depth for SCLK/SS_n/MOSI; minimum 2.

- clk  in  1  system clock (133.33 MHz nominal).
- reset_n  in  1  asynchronous, active-low reset.
- SCLK  in  1  SPI clock from master.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  master-out data.
- MISO  out  1  slave-out data; 0 when not selected.
- MISO_oe  out  1  pad output enable; high only while SS_n (synchronized) is low.
- mem_addr  in  3  register address.
- data_from_cpu  in  16  write data.
- data_to_cpu  out  16  registered read data.
- read_n, write_n  in  1  active-low access strobes.
- spi_select  in  1  chip select for the register port.
- irq  out  1  registered interrupt.
- dataavailable  out  1  = RRDY.
- readyfordata  out  1  = TRDY.

## Operation
- Register map:
  - 0 rxdata: read-only. A read clears RRDY.
  - 1 txdata: write-only. Loads tx holding and sets tx_primed if TRDY; otherwise sets TOE and the data is dropped.
  - 2 status: bits E[8]=TOE|ROE|TUE, RRDY[7], TRDY[6], TMT[5], TOE[4], ROE[3], TUE[2]. Any write clears RRDY, TOE, ROE and TUE; the write data is ignored.
  - 3 control: enables iE[8], iRRDY[7], iTRDY[6], iTOE[4], iROE[3], iTUE[2]. Read-back shows the same bit positions.
  - Any other address reads 0.
- Bus access:
  - Read and write are two-cycle events. The action fires only on the first cycle of spi_select & ~read_n (or ~write_n), using the same `rd_strobe`/`wr_strobe` edge style as the master.
- Flags:
  - TRDY = ~tx_primed.
  - TMT = ~tx_primed & ~busy, where busy = SS selected & bitcount≠0.
- Frame handling:
  - s_sclk, s_ss, s_mosi are the last synchronizer stages. rise = s_sclk & ~s_sclk_d; fall = ~s_sclk & s_sclk_d; ss_fall/ss_rise are defined the same way on s_ss.
  - Load event (ss_fall, or fall while selected with bitcount==0 after a completed byte): tx_shift <= tx_primed ? tx_holding : 0.
    - tx_primed clears on load.
    - loaded_empty <= ~tx_primed.
  - rise while selected: rx_shift <= {rx_shift, s_mosi} and bitcount++.
    - If bitcount==0 and loaded_empty, set TUE.
  - fall while selected with bitcount≠0: tx_shift <<= 1. MISO = tx_shift[MSB] while selected.
  - bitcount reaching DATABITS on a rise (byte complete):
    - rx_holding <= completed byte; RRDY <= 1.
    - ROE <= 1 if RRDY was already 1 and not being cleared by a read in the same cycle.
    - bitcount <= 0.
- Boundary cases:
  - ss_rise mid-byte: bitcount <= 0 and the partial rx byte is discarded. RRDY, rx_holding and tx_holding are unchanged; the partially sent tx byte is lost.
  - SCLK edges while SS_n is high are ignored.
  - CPU txdata write in the same cycle as a load with tx_primed=0: the load takes 0 (loaded_empty=1) and the write fills tx_holding for the next byte.
  - Byte complete in the same cycle as an rxdata read or status write: the set wins for RRDY, and ROE is not set.
- irq_reg <= (E&iE) | (RRDY&iRRDY) | (TRDY&iTRDY) | (TOE&iTOE) | (ROE&iROE) | (TUE&iTUE).
- Reset values:
  - All flags 0; TRDY=1, TMT=1.
  - data_to_cpu=0, irq=0, MISO=0, MISO_oe=0, dataavailable=0, readyfordata=1.
  - Control register 0; shift registers and bitcount 0.
  - Synchronizers reset to SCLK=0, SS_n=1, MOSI=0.

## Timing
- Input to edge detect: SYNC_STAGES+1 clk cycles (3 at default) from the first clk that samples the pin change until the register update.
- Pin-to-pin latency:
  - MISO update after a SCLK falling edge: ≤ 4 clk (30 ns).
  - MISO valid after an SS_n falling edge: ≤ 4 clk.
  - RRDY/dataavailable after the 8th SCLK rise: ≤ 4 clk; irq one cycle later.
- SCLK high and low phases must each be ≥ 4 clk (SCLK ≤ clk/8 ≈ 16.6 MHz). SS_n fall to first SCLK rise must be ≥ 5 clk.
- data_to_cpu is valid the cycle after the first read cycle.
- TRDY rises the cycle after a load.

## Test plan
- Reset mid-frame (SS_n low, 3 bits clocked) -> all outputs at reset values; the next full frame works normally.
- CPU writes 0xA5 to txdata, master clocks 0x3C at 16 MHz -> MISO bits 1,0,1,0,0,1,0,1; rxdata=0x3C; RRDY=1; TRDY=1 after load; TMT=1 at end.
- Two back-to-back bytes in one SS frame with tx 0x11 then 0x22 written while TRDY=1 -> master sees 0x11,0x22. Second byte completes without an rxdata read -> ROE=1, rxdata=second byte, irq with iROE=1.
- No txdata written, SS_n fall, 8 clocks -> MISO all 0, TUE=1, E=1. A status write clears TUE/E.
- txdata written twice while a byte is shifting and holding is full -> second write sets TOE; holding keeps the first value.
- SS_n deasserted after 5 bits, then a new 8-bit frame 0xC3 -> rxdata=0xC3, RRDY set once, no ROE; MISO_oe low between frames.
